uart_word_monitor: RTL and testbench
====================================

UART_WORD_MONITOR -- requirements
Module: uart_word_monitor

Interface
REQ-001 SHALL have parameter WAIT, default 8, meaning clocks per UART bit (even, >= 4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the word FIFO depth (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have port rxd, input, 1, the serial line from the DUT UART TX (idle high).
REQ-006 SHALL have port clr, input, 1, which clears the sticky error flags.
REQ-007 SHALL have port word_ready, input, 1, the consumer pop request.
REQ-008 SHALL have port word_valid, output, 1, which is high when the FIFO is non-empty.
REQ-009 SHALL have port word_data, output, 32, the FIFO head word (show-ahead).
REQ-010 SHALL have port frame_err, output, 1, a sticky flag set on a bad stop bit.
REQ-011 SHALL have port overflow, output, 1, a sticky flag set when a word is dropped because the FIFO is full.
REQ-012 SHALL have port byte_cnt, output, 2, the number of bytes in the current partial word.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-015 SHALL, in IDLE, detect a falling edge on synchronized rxd and go to START with the bit timer cleared.
REQ-016 SHALL, in START, sample at WAIT/2 clocks: low -> DATA with timer cleared; high -> glitch, back to IDLE with no flag set.
REQ-017 SHALL, in DATA, sample every WAIT clocks, 8 bits LSB first, then go to STOP.
REQ-018 SHALL, in STOP, sample after WAIT clocks: high -> byte accepted; low -> byte discarded and frame_err set; either way return to IDLE.
REQ-019 SHALL pack accepted bytes little-endian: byte n goes to bits [8n+7:8n]; byte_cnt increments and wraps 3 -> 0 on the 4th byte.
REQ-020 SHALL push the word into the FIFO on the cycle after the 4th byte is accepted; word_valid rises one cycle later.
REQ-021 SHALL pop when word_valid && word_ready; word_ready with the FIFO empty has no effect.
REQ-022 SHALL, on a push while full with no pop, drop the new word, set overflow, and leave FIFO contents unchanged.
REQ-023 SHALL, on simultaneous push and pop while full, accept both; count stays DEPTH and overflow is not set.
REQ-024 SHALL keep byte_cnt unchanged on a discarded (framing-error) byte.
REQ-025 SHALL clear frame_err and overflow on clr; if a set event occurs in the same cycle, set wins.

Reset
REQ-026 SHALL, on rst assertion, immediately force the FSM to IDLE and set byte_cnt=0, word_valid=0, word_data=0, frame_err=0, overflow=0, FIFO empty, and synchronizer flops to 1.
REQ-027 SHALL discard a frame or partial word in progress at reset; no word is pushed.
REQ-028 SHALL treat rxd held low at reset release as not an edge; reception waits for a high then a falling edge.

Configuration
REQ-029 SHALL, with UART_WORD_MONITOR_PARITY_EN defined, expect an even-parity bit after bit 7 (DATA samples 9 bits); a parity mismatch discards the byte and sets frame_err.
REQ-030 SHALL, without UART_WORD_MONITOR_PARITY_EN, use a 10-bit frame (8N1) with no parity logic.

Structure
REQ-031 SHALL place the FSM state enum, the default WAIT value (8), and the frame bit counts in shared package test_package.
REQ-032 SHALL implement the FIFO as sub-module word_fifo (push, pop, full, empty, head, synchronous storage, asynchronous reset).

Verification
REQ-033 Send bytes 0x78,0x56,0x34,0x12 with WAIT=8 -> word_valid rises once, word_data=0x12345678, byte_cnt=0, no flags set.
REQ-034 Drive a 3-clock low pulse on idle rxd -> FSM returns to IDLE, byte_cnt=0, frame_err=0.
REQ-035 Send byte 0xAA with stop bit low -> frame_err=1 and byte_cnt unchanged; then pulse clr -> frame_err=0.
REQ-036 Send 5 words with DEPTH=4 and word_ready=0 -> overflow=1; pop 4 times -> words 1-4 returned in order, then word_valid=0.
REQ-037 Hold word_ready=1 while filling to full, with push and pop in the same cycle -> overflow stays 0 and all words are returned in order.
REQ-038 Assert rst after 2 bytes of a word, then send 0x01,0x00,0x00,0x00 -> word_data=0x00000001.

Source files
------------

// File: rtl/uart_word_monitor_pkg.sv
// Shared FSM state type and frame constants for the UART word monitor.
// UART_WORD_MONITOR_PARITY_EN adds one even-parity bit after the data bits.
package test_package;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_WAIT = 8;
  localparam int DATA_BITS    = 8;
`ifdef UART_WORD_MONITOR_PARITY_EN
  localparam int PARITY_BITS  = 1;
`else
  localparam int PARITY_BITS  = 0;
`endif
  localparam int SAMPLE_BITS  = DATA_BITS + PARITY_BITS;
  localparam int FRAME_BITS   = SAMPLE_BITS + 2;

endpackage

// File: rtl/uart_word_monitor_word_fifo.sv
// Show-ahead word FIFO: head is valid combinationally, one-cycle push-to-visible.
// A push while full is accepted only if a pop happens in the same cycle.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Empty FIFO presents zero rather than stale storage.
  assign o_head    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_monitor.sv
// Receives 8N1 UART bytes (8E1 with UART_WORD_MONITOR_PARITY_EN), packs four into a
// little-endian word and queues it; word visible two cycles after the 4th stop sample.
module uart_word_monitor
  import test_package::*;
#(
  parameter int WAIT  = DEFAULT_WAIT,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        clr,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic        frame_err,
  output logic        overflow,
  output logic [1:0]  byte_cnt
);

  localparam int TW = (WAIT > 2) ? $clog2(WAIT) : 1;
  localparam int BW = $clog2(SAMPLE_BITS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(WAIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(WAIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SAMPLE_BITS - 1);

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_prev;
  logic                   r_live;
  logic                   r_armed;
  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic [BW-1:0]          r_bit;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic [31:0]            r_word;
  logic [1:0]             r_cnt;
  logic                   r_push;
  logic                   r_frame_err;
  logic                   r_overflow;

  logic                   w_rx;
  logic                   w_fall;
  logic                   w_half;
  logic                   w_full_tick;
  logic                   w_stop_smp;
  logic                   w_par_ok;
  logic                   w_accept;
  logic                   w_reject;
  logic [7:0]             w_byte;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic                   w_ovf_set;

  assign w_rx        = r_sync2;
  // A low line at reset release is not an edge: arm only once a real high is seen.
  assign w_fall      = r_armed & r_prev & ~w_rx;
  assign w_half      = (r_timer == HALF_M1);
  assign w_full_tick = (r_timer == FULL_M1);
  assign w_stop_smp  = (r_state == ST_STOP) & w_full_tick;
  assign w_byte      = r_shift[DATA_BITS-1:0];
`ifdef UART_WORD_MONITOR_PARITY_EN
  assign w_par_ok    = ~(^r_shift);
`else
  assign w_par_ok    = 1'b1;
`endif
  assign w_accept    = w_stop_smp & w_rx & w_par_ok;
  assign w_reject    = w_stop_smp & ~(w_rx & w_par_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_live  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_live  <= 1'b1;
      r_armed <= r_armed | (r_live & r_sync1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_fall) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_half) begin
            r_timer <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_full_tick) begin
            r_timer <= '0;
            r_shift <= {w_rx, r_shift[SAMPLE_BITS-1:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == LAST_BIT) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_full_tick) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The completed word is pushed from r_word the cycle after the 4th byte lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_push <= 1'b0;
    end else begin
      r_push <= w_accept & (r_cnt == 2'd3);
      if (w_accept) begin
        r_word[8*r_cnt +: 8] <= w_byte;
        r_cnt                <= r_cnt + 1'b1;
      end
    end
  end

  assign w_pop     = word_valid & word_ready;
  assign w_ovf_set = r_push & w_fifo_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_reject | (r_frame_err & ~clr);
      r_overflow  <= w_ovf_set | (r_overflow & ~clr);
    end
  end

  word_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_dat   (r_word),
    .i_pop   (word_ready),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (word_data)
  );

  assign word_valid = ~w_fifo_empty;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign byte_cnt   = r_cnt;

endmodule

// File: tb/tb_uart_word_monitor.sv
// Bench for uart_word_monitor: table-driven frames, directed corner sequences and
// random traffic checked against a byte/word queue model.
module tb_uart_word_monitor;
  import test_package::*;

  localparam int WAIT    = 8;
  localparam int DEPTH   = 4;
  localparam int GAP     = 2 * WAIT;
  localparam int POP_WIN = 4 * WAIT;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        clr;
  logic        word_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        frame_err;
  logic        overflow;
  logic [1:0]  byte_cnt;

  always #5 clk = ~clk;

  uart_word_monitor #(.WAIT(WAIT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .clr        (clr),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .byte_cnt   (byte_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: accepted bytes, queued words, popped words, sticky flags.
  logic [31:0] m_exp[$];
  logic [31:0] m_got[$];
  logic [7:0]  m_part[4];
  int          m_occ;
  int          m_cnt;
  bit          m_fe;
  bit          m_ovf;

  typedef struct {
    logic [7:0]  dat;
    logic        stop;
    logic        do_clr;
    logic [1:0]  cnt;
    logic        fe;
    logic        wv;
    logic [31:0] wdat;
  } vec_t;

  vec_t tbl[6];
  int   lat_rise;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset;
    m_exp.delete();
    m_got.delete();
    m_occ = 0;
    m_cnt = 0;
    m_fe  = 1'b0;
    m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_part[i] = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] d, input bit ok);
    logic [31:0] w;
    if (!ok) begin
      m_fe = 1'b1;
    end else begin
      m_part[m_cnt] = d;
      m_cnt = (m_cnt + 1) % 4;
      if (m_cnt == 0) begin
        w = {m_part[3], m_part[2], m_part[1], m_part[0]};
        if (m_occ >= DEPTH) m_ovf = 1'b1;
        else begin
          m_occ++;
          m_exp.push_back(w);
        end
      end
    end
  endtask

  task automatic compare_streams;
    while (m_got.size() > 0 && m_exp.size() > 0)
      check("pop_order", m_got.pop_front(), m_exp.pop_front());
  endtask

  task automatic check_state(input string tag);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_fe));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_word_valid"}, 32'(word_valid), 32'(m_occ > 0));
    if (m_got.size() == 0 && m_exp.size() > 0)
      check({tag, "_word_data"}, word_data, m_exp[0]);
  endtask

  task automatic do_reset(input logic line);
    rst = 1'b1;
    rxd = line;
    clr = 1'b0;
    word_ready = 1'b0;
    tick;
    tick;
    model_reset();
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_data", word_data, 32'h0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_flags", {30'd0, frame_err, overflow}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    m_fe  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic pop_one;
    word_ready = 1'b1;
    if (word_valid) begin
      m_got.push_back(word_data);
      m_occ--;
    end
    tick;
    word_ready = 1'b0;
    compare_streams();
  endtask

  // hold: 0 = never ready, 1 = ready early in the frame only, 2 = always ready.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int hold, input int ready_at, output int rise);
    logic [FRAME_BITS-1:0] bits;
    logic wv_prev;
    bits = '0;
    bits[8:1] = d;
`ifdef UART_WORD_MONITOR_PARITY_EN
    bits[9] = (^d) ^ ~par_ok;
`endif
    bits[FRAME_BITS-1] = stop_ok;
    rise = -1;
    for (int n = 0; n < FRAME_BITS * WAIT + GAP; n++) begin
      rxd = (n < FRAME_BITS * WAIT) ? bits[n / WAIT] : 1'b1;
      word_ready = (n == ready_at) || (hold == 2) || (hold == 1 && n < POP_WIN);
      wv_prev = word_valid;
      if (word_ready && word_valid) begin
        m_got.push_back(word_data);
        m_occ--;
      end
      tick;
      if (rise < 0 && !wv_prev && word_valid) rise = n;
    end
    word_ready = 1'b0;
    model_accept(d, stop_ok && par_ok);
    compare_streams();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   rise;
    logic [7:0] d;
    bit   sok;
    bit   pok;
    int   hold;

    tbl[0] = '{8'h78, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{8'h56, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{8'h34, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{8'h12, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h12345678};
    tbl[4] = '{8'hAA, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'h12345678};
    tbl[5] = '{8'h11, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 32'h12345678};
    lat_rise = -1;

    do_reset(1'b1);
    repeat (4) tick;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dat, tbl[i].stop, 1'b1, 0, -1, rise);
      if (i == 3) begin
        lat_rise = rise;
        check("t_valid_rise_seen", 32'(rise >= 0), 32'd1);
      end
      if (tbl[i].do_clr) pulse_clr();
      check($sformatf("t%0d_byte_cnt", i), 32'(byte_cnt), 32'(tbl[i].cnt));
      check($sformatf("t%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].fe));
      check($sformatf("t%0d_overflow", i), 32'(overflow), 32'd0);
      check($sformatf("t%0d_word_valid", i), 32'(word_valid), 32'(tbl[i].wv));
      if (tbl[i].wv) check($sformatf("t%0d_word_data", i), word_data, tbl[i].wdat);
    end
    pop_one();
    check("t_after_pop_valid", 32'(word_valid), 32'd0);

    // Short low pulse must be rejected as a glitch.
    do_reset(1'b1);
    repeat (4) tick;
    rxd = 1'b0;
    repeat (3) tick;
    rxd = 1'b1;
    repeat (3 * WAIT) tick;
    check("glitch_byte_cnt", 32'(byte_cnt), 32'd0);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_word_valid", 32'(word_valid), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 0, -1, rise);
    check_state("glitch_recover");

    // Line held low through reset release must not start a frame.
    do_reset(1'b0);
    repeat (2 * FRAME_BITS * WAIT) tick;
    check("lowrst_frame_err", 32'(frame_err), 32'd0);
    check("lowrst_byte_cnt", 32'(byte_cnt), 32'd0);
    rxd = 1'b1;
    repeat (2 * WAIT) tick;
    send_frame(8'hC3, 1'b1, 1'b1, 0, -1, rise);
    check_state("lowrst_recover");

    // Reset mid-word and mid-frame discards the partial word.
    do_reset(1'b1);
    repeat (4) tick;
    send_frame(8'hEE, 1'b1, 1'b1, 0, -1, rise);
    send_frame(8'hDD, 1'b1, 1'b1, 0, -1, rise);
    check("midrst_pre_cnt", 32'(byte_cnt), 32'd2);
    rxd = 1'b0;
    repeat (3 * WAIT) tick;
    do_reset(1'b1);
    repeat (4) tick;
    send_frame(8'h01, 1'b1, 1'b1, 0, -1, rise);
    send_frame(8'h00, 1'b1, 1'b1, 0, -1, rise);
    send_frame(8'h00, 1'b1, 1'b1, 0, -1, rise);
    send_frame(8'h00, 1'b1, 1'b1, 0, -1, rise);
    check("midrst_word_data", word_data, 32'h00000001);
    check_state("midrst");

    // Five words into a four-deep FIFO with no consumer.
    do_reset(1'b1);
    repeat (4) tick;
    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1, 0, -1, rise);
    end
    check_state("ovf_fill");
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_one();
    check("ovf_drained_valid", 32'(word_valid), 32'd0);

    // Push and pop in the same cycle while full.
    pulse_clr();
    check("simul_clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b1, 0, -1, rise);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b1, 0, -1, rise);
    send_frame(8'($urandom), 1'b1, 1'b1, 0, lat_rise, rise);
    check("simul_no_ovf", 32'(overflow), 32'd0);
    check_state("simul");
    for (int i = 0; i < 4; i++) pop_one();
    check("simul_drained_valid", 32'(word_valid), 32'd0);

    // Consumer always ready while words stream in.
    for (int i = 0; i < 12; i++) send_frame(8'($urandom), 1'b1, 1'b1, 2, -1, rise);
    check("ready_no_ovf", 32'(overflow), 32'd0);
    check_state("ready_stream");

    // Random traffic with framing errors, consumer gaps and clears.
    do_reset(1'b1);
    repeat (4) tick;
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      sok  = ($urandom_range(0, 7) != 0);
      pok  = 1'b1;
`ifdef UART_WORD_MONITOR_PARITY_EN
      pok  = ($urandom_range(0, 7) != 0);
`endif
      hold = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_frame(d, sok, pok, hold, -1, rise);
      check_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 9) == 0) pulse_clr();
    end
    for (int i = 0; i < DEPTH + 2 && word_valid; i++) pop_one();
    check("rnd_final_valid", 32'(word_valid), 32'd0);
    check("rnd_unmatched_pops", 32'(m_got.size()), 32'd0);
    check("rnd_unreturned_words", 32'(m_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
